// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - decode/issue bus between the fetch side and the ID/EX slot
interface alu_issue_stage_if #(
    parameter int XLEN = 32
);
    // Upstream instruction, operands and pipeline control
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            stall;
    logic            flush;

    // Registered ID/EX slot contents
    logic            ex_valid;
    logic [5:0]      ALU_Control;
    logic            branch_op;
    logic [XLEN-1:0] operand_A;
    logic [XLEN-1:0] operand_B;
    logic [XLEN-1:0] target;
    logic [4:0]      rd;
    logic            reg_write;
    logic [XLEN-1:0] store_data;
    logic            mem_read;
    logic            mem_write;
    logic            illegal;

    // Upstream/pipeline-control side: drives instructions, observes the slot
    modport master (
        output in_valid, instruction, pc, rs1_data, rs2_data, stall, flush,
        input  in_ready, ex_valid, ALU_Control, branch_op, operand_A, operand_B,
        input  target, rd, reg_write, store_data, mem_read, mem_write, illegal
    );

    // Issue stage side: consumes instructions, owns the slot
    modport slave (
        input  in_valid, instruction, pc, rs1_data, rs2_data, stall, flush,
        output in_ready, ex_valid, ALU_Control, branch_op, operand_A, operand_B,
        output target, rd, reg_write, store_data, mem_read, mem_write, illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32I decode and operand select into a registered ID/EX slot
module alu_issue_stage #(
    parameter int         XLEN     = 32,
    parameter logic [5:0] NOP_CTRL = 6'b000000
) (
    input  logic              clock,
    input  logic              reset,
    alu_issue_stage_if.slave  bus
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [XLEN-1:0] LINK_OFFSET = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK  = ~XLEN'(1);

    // Instruction fields
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_field;

    assign instr    = bus.instruction;
    assign opcode   = instr[6:0];
    assign rd_field = instr[11:7];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];

    // Immediates, first in 32-bit RV32I form, then sign-extended to XLEN
    logic [31:0]     imm_i32, imm_s32, imm_b32, imm_u32, imm_j32;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i32 = {{20{instr[31]}}, instr[31:20]};
    assign imm_s32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u32 = {instr[31:12], 12'b0};
    assign imm_j32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign imm_i = XLEN'($signed(imm_i32));
    assign imm_s = XLEN'($signed(imm_s32));
    assign imm_b = XLEN'($signed(imm_b32));
    assign imm_u = XLEN'($signed(imm_u32));
    assign imm_j = XLEN'($signed(imm_j32));

    // Decoded values that the slot captures on a load
    logic [5:0]      d_ctrl;
    logic            d_bop;
    logic [XLEN-1:0] d_a;
    logic [XLEN-1:0] d_b;
    logic [XLEN-1:0] d_tgt;
    logic [XLEN-1:0] d_sd;
    logic            d_writes;
    logic            d_rw;
    logic            d_mr;
    logic            d_mw;
    logic            d_ill;

    // Decode the incoming instruction: control, operands, target and tags
    always_comb begin
        d_ctrl   = NOP_CTRL;
        d_bop    = 1'b0;
        d_a      = '0;
        d_b      = '0;
        d_tgt    = '0;
        d_sd     = '0;
        d_writes = 1'b0;
        d_mr     = 1'b0;
        d_mw     = 1'b0;
        d_ill    = 1'b0;

        case (opcode)
            OPC_OP: begin
                d_a      = bus.rs1_data;
                d_b      = bus.rs2_data;
                d_writes = 1'b1;
                d_ctrl   = {2'b00, funct7[5], funct3};
                // Only ADD/SUB and SRL/SRA have an alternate funct7 encoding
                if (funct7 == 7'h00) begin
                    d_ill = 1'b0;
                end else if (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    d_ill = 1'b0;
                end else begin
                    d_ill = 1'b1;
                end
            end
            OPC_OPIMM: begin
                d_a      = bus.rs1_data;
                d_b      = imm_i;
                d_writes = 1'b1;
                d_ctrl   = {3'b000, funct3};
                if (funct3 == 3'b001 && funct7 != 7'h00) begin
                    d_ill = 1'b1;
                end
                if (funct3 == 3'b101) begin
                    if (funct7 == 7'h20) begin
                        d_ctrl = 6'b001101;
                    end else if (funct7 != 7'h00) begin
                        d_ill = 1'b1;
                    end
                end
            end
            OPC_LOAD: begin
                d_a      = bus.rs1_data;
                d_b      = imm_i;
                d_ctrl   = 6'b000000;
                d_writes = 1'b1;
                d_mr     = 1'b1;
            end
            OPC_STORE: begin
                d_a    = bus.rs1_data;
                d_b    = imm_s;
                d_ctrl = 6'b000000;
                d_sd   = bus.rs2_data;
                d_mw   = 1'b1;
            end
            OPC_BRANCH: begin
                d_a    = bus.rs1_data;
                d_b    = bus.rs2_data;
                d_ctrl = {3'b010, funct3};
                d_bop  = 1'b1;
                d_tgt  = bus.pc + imm_b;
                if (funct3 == 3'b010 || funct3 == 3'b011) begin
                    d_ill = 1'b1;
                end
            end
            OPC_LUI: begin
                d_b      = imm_u;
                d_ctrl   = 6'b000000;
                d_writes = 1'b1;
            end
            OPC_AUIPC: begin
                d_a      = bus.pc;
                d_b      = imm_u;
                d_ctrl   = 6'b000000;
                d_writes = 1'b1;
            end
            OPC_JAL: begin
                // ALU passes operand_A through to form the link value
                d_a      = bus.pc + LINK_OFFSET;
                d_ctrl   = 6'b011111;
                d_tgt    = bus.pc + imm_j;
                d_writes = 1'b1;
            end
            OPC_JALR: begin
                d_a      = bus.pc + LINK_OFFSET;
                d_ctrl   = 6'b111111;
                d_tgt    = (bus.rs1_data + imm_i) & ALIGN_MASK;
                d_writes = 1'b1;
            end
            default: begin
                d_ill = 1'b1;
            end
        endcase

        // An illegal instruction still reaches execute, but with no side effects
        if (d_ill) begin
            d_ctrl = NOP_CTRL;
            d_bop  = 1'b0;
            d_mr   = 1'b0;
            d_mw   = 1'b0;
        end
        d_rw = d_writes && (rd_field != 5'd0) && !d_ill;
    end

    assign bus.in_ready = !bus.stall;

    // ID/EX slot: reset, then flush or bubble, then stall hold, then load
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.ex_valid    <= 1'b0;
            bus.ALU_Control <= NOP_CTRL;
            bus.branch_op   <= 1'b0;
            bus.operand_A   <= '0;
            bus.operand_B   <= '0;
            bus.target      <= '0;
            bus.rd          <= 5'd0;
            bus.reg_write   <= 1'b0;
            bus.store_data  <= '0;
            bus.mem_read    <= 1'b0;
            bus.mem_write   <= 1'b0;
            bus.illegal     <= 1'b0;
        end else if (bus.flush || (!bus.stall && !bus.in_valid)) begin
            bus.ex_valid    <= 1'b0;
            bus.ALU_Control <= NOP_CTRL;
            bus.branch_op   <= 1'b0;
            bus.operand_A   <= '0;
            bus.operand_B   <= '0;
            bus.target      <= '0;
            bus.rd          <= 5'd0;
            bus.reg_write   <= 1'b0;
            bus.store_data  <= '0;
            bus.mem_read    <= 1'b0;
            bus.mem_write   <= 1'b0;
            bus.illegal     <= 1'b0;
        end else if (!bus.stall) begin
            bus.ex_valid    <= 1'b1;
            bus.ALU_Control <= d_ctrl;
            bus.branch_op   <= d_bop;
            bus.operand_A   <= d_a;
            bus.operand_B   <= d_b;
            bus.target      <= d_tgt;
            bus.rd          <= rd_field;
            bus.reg_write   <= d_rw;
            bus.store_data  <= d_sd;
            bus.mem_read    <= d_mr;
            bus.mem_write   <= d_mw;
            bus.illegal     <= d_ill;
        end
    end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed-vector bench for the ALU issue stage
module tb_alu_issue_stage;
    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    alu_issue_stage_if #(.XLEN(32)) bus ();

    alu_issue_stage #(.XLEN(32), .NOP_CTRL(6'b000000)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pcv,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic st, input logic fl);
        bus.in_valid    = v;
        bus.instruction = ins;
        bus.pc          = pcv;
        bus.rs1_data    = r1;
        bus.rs2_data    = r2;
        bus.stall       = st;
        bus.flush       = fl;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic slot(input string tag, input logic ev, input logic [5:0] ctrl, input logic bop,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] tgt,
                        input logic [4:0] rdv, input logic rw, input logic mr, input logic mw,
                        input logic ill);
        chk({tag, ".ex_valid"},  32'(bus.ex_valid),    32'(ev));
        chk({tag, ".ctrl"},      32'(bus.ALU_Control), 32'(ctrl));
        chk({tag, ".branch_op"}, 32'(bus.branch_op),   32'(bop));
        chk({tag, ".A"},         bus.operand_A,        a);
        chk({tag, ".B"},         bus.operand_B,        b);
        chk({tag, ".target"},    bus.target,           tgt);
        chk({tag, ".rd"},        32'(bus.rd),          32'(rdv));
        chk({tag, ".reg_write"}, 32'(bus.reg_write),   32'(rw));
        chk({tag, ".mem_read"},  32'(bus.mem_read),    32'(mr));
        chk({tag, ".mem_write"}, 32'(bus.mem_write),   32'(mw));
        chk({tag, ".illegal"},   32'(bus.illegal),     32'(ill));
    endtask

    task automatic bubble(input string tag);
        chk({tag, ".ex_valid"},  32'(bus.ex_valid),    32'd0);
        chk({tag, ".ctrl"},      32'(bus.ALU_Control), 32'd0);
        chk({tag, ".branch_op"}, 32'(bus.branch_op),   32'd0);
        chk({tag, ".reg_write"}, 32'(bus.reg_write),   32'd0);
        chk({tag, ".mem_read"},  32'(bus.mem_read),    32'd0);
        chk({tag, ".mem_write"}, 32'(bus.mem_write),   32'd0);
        chk({tag, ".illegal"},   32'(bus.illegal),     32'd0);
    endtask

    task automatic illegal_slot(input string tag);
        chk({tag, ".ex_valid"},  32'(bus.ex_valid),    32'd1);
        chk({tag, ".illegal"},   32'(bus.illegal),     32'd1);
        chk({tag, ".ctrl"},      32'(bus.ALU_Control), 32'd0);
        chk({tag, ".branch_op"}, 32'(bus.branch_op),   32'd0);
        chk({tag, ".reg_write"}, 32'(bus.reg_write),   32'd0);
        chk({tag, ".mem_read"},  32'(bus.mem_read),    32'd0);
        chk({tag, ".mem_write"}, 32'(bus.mem_write),   32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        slot("reset", 1'b0, 6'h00, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.in_ready",   32'(bus.in_ready), 32'd1);
        chk("reset.store_data", bus.store_data,    32'h0);
        reset = 1'b0;

        // Register-register ALU ops
        drive(1'b1, 32'h002081B3, 32'h100, 32'd4, 32'd5, 1'b0, 1'b0);
        tick();
        slot("add", 1'b1, 6'h00, 1'b0, 32'd4, 32'd5, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h402081B3, 32'h104, 32'd4, 32'd5, 1'b0, 1'b0);
        tick();
        slot("sub", 1'b1, 6'h08, 1'b0, 32'd4, 32'd5, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h00208033, 32'h108, 32'd4, 32'd5, 1'b0, 1'b0);
        tick();
        slot("add_x0", 1'b1, 6'h00, 1'b0, 32'd4, 32'd5, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Branch, jumps, upper immediates, shift immediate
        drive(1'b1, 32'h00208463, 32'h200, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        tick();
        slot("beq", 1'b1, 6'h10, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h208, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h010000EF, 32'h300, 32'h55, 32'h66, 1'b0, 1'b0);
        tick();
        slot("jal", 1'b1, 6'h1F, 1'b0, 32'h304, 32'h0, 32'h310, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h004100E7, 32'h400, 32'h1001, 32'h0, 1'b0, 1'b0);
        tick();
        slot("jalr", 1'b1, 6'h3F, 1'b0, 32'h404, 32'h0, 32'h1004, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h123452B7, 32'h500, 32'hDEAD, 32'h0, 1'b0, 1'b0);
        tick();
        slot("lui", 1'b1, 6'h00, 1'b0, 32'h0, 32'h12345000, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h4010D193, 32'h504, 32'h80000000, 32'h0, 1'b0, 1'b0);
        tick();
        slot("srai", 1'b1, 6'h0D, 1'b0, 32'h80000000, 32'h401, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("srai.shamt", 32'(bus.operand_B[4:0]), 32'd1);

        // Memory ops
        drive(1'b1, 32'h0020A423, 32'h600, 32'h1000, 32'hCAFEBABE, 1'b0, 1'b0);
        tick();
        slot("sw", 1'b1, 6'h00, 1'b0, 32'h1000, 32'h8, 32'h0, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("sw.store_data", bus.store_data, 32'hCAFEBABE);
        drive(1'b1, 32'hFFC0A183, 32'h604, 32'h1000, 32'h0, 1'b0, 1'b0);
        tick();
        slot("lw", 1'b1, 6'h00, 1'b0, 32'h1000, 32'hFFFFFFFC, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);

        // Illegal encodings
        drive(1'b1, 32'h0000017F, 32'h700, 32'h1, 32'h2, 1'b0, 1'b0);
        tick();
        illegal_slot("bad_opcode");
        drive(1'b1, 32'h022081B3, 32'h704, 32'h1, 32'h2, 1'b0, 1'b0);
        tick();
        illegal_slot("op_funct7");
        drive(1'b1, 32'h0020A463, 32'h708, 32'h1, 32'h2, 1'b0, 1'b0);
        tick();
        illegal_slot("branch_f3");
        drive(1'b1, 32'h40109193, 32'h70C, 32'h1, 32'h2, 1'b0, 1'b0);
        tick();
        illegal_slot("slli_f7");

        // Stall holds the slot for three cycles while inputs change
        drive(1'b1, 32'h002081B3, 32'h100, 32'd4, 32'd5, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h402081B3, 32'h800, 32'd9, 32'd7, 1'b1, 1'b0);
        #1;
        chk("stall.in_ready", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            slot("stall", 1'b1, 6'h00, 1'b0, 32'd4, 32'd5, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
            drive(1'b1, 32'h00208463 + 32'(i << 7), 32'h900 + 32'(i), 32'(i), 32'(i + 1), 1'b1, 1'b0);
        end

        // Flush beats stall
        drive(1'b1, 32'h402081B3, 32'h800, 32'd9, 32'd7, 1'b1, 1'b1);
        tick();
        bubble("stall_flush");

        // No valid input with no stall loads a bubble
        drive(1'b1, 32'h002081B3, 32'h100, 32'd4, 32'd5, 1'b0, 1'b0);
        tick();
        chk("pre_bubble.ex_valid", 32'(bus.ex_valid), 32'd1);
        drive(1'b0, 32'h002081B3, 32'h100, 32'd4, 32'd5, 1'b0, 1'b0);
        tick();
        bubble("in_valid_low");

        // Reset clears a live slot even with stall asserted
        drive(1'b1, 32'h002081B3, 32'h100, 32'd4, 32'd5, 1'b0, 1'b0);
        tick();
        chk("pre_reset.reg_write", 32'(bus.reg_write), 32'd1);
        drive(1'b1, 32'h002081B3, 32'h100, 32'd4, 32'd5, 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        slot("mid_reset", 1'b0, 6'h00, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Branch target wrap-around
        drive(1'b1, 32'h00208463, 32'hFFFFFFFC, 32'h1, 32'h1, 1'b0, 1'b0);
        tick();
        slot("beq_wrap", 1'b1, 6'h10, 1'b1, 32'h1, 32'h1, 32'h4, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode-to-execute issue register that generates every input the ALU consumes: ALU_Control, branch_op, operand_A, operand_B.
- Decodes one RV32I instruction per cycle, selects operands, and registers the results into an ID/EX pipeline slot.
- Supports stall, which holds the slot, and flush, which inserts a bubble.
- Also produces the registered branch/jump target and the register-writeback tags for the execute stage.

Parameters:
- XLEN, 32, data/address width.
- NOP_CTRL, 6'b000000, ALU_Control value driven on bubbles (ADD).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction/pc/rs data valid this cycle.
- in_ready  out  1  stage can accept; equals !stall.
- instruction  in  32  raw RV32I instruction.
- pc  in  XLEN  address of instruction.
- rs1_data  in  XLEN  register file read port 1.
- rs2_data  in  XLEN  register file read port 2.
- stall  in  1  hold current slot contents.
- flush  in  1  kill current slot and the incoming instruction.
- ex_valid  out  1  slot holds a live instruction.
- ALU_Control  out  6  ALU operation encoding.
- branch_op  out  1  ALU result is a branch condition.
- operand_A  out  XLEN  ALU operand A.
- operand_B  out  XLEN  ALU operand B.
- target  out  XLEN  branch/jump target.
- rd  out  5  destination register.
- reg_write  out  1  instruction writes rd (0 when rd==0).
- store_data  out  XLEN  rs2_data for stores.
- mem_read  out  1  load.
- mem_write  out  1  store.
- illegal  out  1  unsupported opcode/funct.

Behaviour:
Reset:
- On reset, all outputs except in_ready are 0; ALU_Control = NOP_CTRL.
- Reset overrides stall and flush.

Pipeline and handshake:
- Latency is 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- Update priority per edge: reset > flush > stall > load.
- flush: ex_valid<=0, reg_write/mem_read/mem_write/illegal<=0, ALU_Control<=NOP_CTRL, branch_op<=0. Other fields are don't-care.
- flush with stall simultaneously: flush wins.
- stall (no flush): all registered outputs hold their values.
- load (no stall, no flush):
  - in_valid=1: capture the decode.
  - in_valid=0: load a bubble, same as flush.
- in_ready is combinational !stall.

ALU_Control encoding, {class[2:0], funct3}:
- OP (0110011): {2'b00, funct7[5], funct3}. funct7[5]=1 is legal only for funct3 000 and 101. Any funct7 other than 0x00 or 0x20 sets illegal.
- OP-IMM (0010011): {3'b000, funct3}, except SRAI = 6'b001101. For SLLI/SRLI/SRAI, bad funct7 sets illegal.
- BRANCH (1100011): {3'b010, funct3}, branch_op=1. funct3 010 and 011 set illegal.
- JAL (1101111): 6'b011111.
- JALR (1100111): 6'b111111.
- LOAD, STORE, LUI, AUIPC: 6'b000000.

Immediates:
- Immediates are sign-extended per I/S/B/U/J format.
- U-immediate is {instr[31:12], 12'b0}.

Operands, as (operand_A; operand_B):
- OP: rs1; rs2.
- OP-IMM, LOAD, STORE: rs1; imm.
- BRANCH: rs1; rs2.
- LUI: 0; imm.
- AUIPC: pc; imm.
- JAL, JALR: pc+4; 0. The ALU passes operand_A through, giving the link value.
- Shift-immediate operand_B: the full sign-extended immediate. The ALU uses only bits [4:0].

Target (all arithmetic modulo 2^XLEN; wrap-around allowed, no flag):
- BRANCH and JAL: pc+imm.
- JALR: (rs1+imm) & ~1.
- Otherwise: 0.

Writeback tags:
- reg_write=1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR, and only when rd!=0.
- mem_read=1 for LOAD; mem_write=1 for STORE.

Illegal instructions:
- Any other opcode sets illegal=1.
- When illegal=1, force reg_write, mem_read, mem_write and branch_op to 0, and set ALU_Control=NOP_CTRL.
- ex_valid stays 1 so the trap logic sees the instruction.

Test Plan:
- ADD, 0x002081B3, rs1=4, rs2=5, pc=0x100 -> next cycle: ex_valid=1, ALU_Control=000000, A=4, B=5, rd=3, reg_write=1. Then SUB, 0x402081B3 -> ALU_Control=001000.
- BEQ +8, 0x00208463, pc=0x200, rs1=rs2=0xFFFFFFFF -> ALU_Control=010000, branch_op=1, A=B=0xFFFFFFFF, target=0x208, reg_write=0.
- JAL x1,+16, 0x010000EF, pc=0x300 -> ALU_Control=011111, A=0x304, target=0x310, rd=1. JALR with rs1=0x1001, imm=4 -> target=0x1004 (bit 0 cleared).
- LUI x5, 0x123452B7 -> A=0, B=0x12345000. SRAI, 0x4010D193 -> ALU_Control=001101, B[4:0]=1. Undefined opcode 0x0000007F -> illegal=1, reg_write=0.
- Stall held 3 cycles while inputs change -> outputs are frozen. Assert stall and flush together -> ex_valid=0, ALU_Control=000000. Then in_valid=0 with no stall -> bubble.
- Assert reset while a valid ADD is in the slot -> next cycle all outputs are 0. Pc=0xFFFFFFFC with BEQ +8 -> target wraps to 0x00000004.
